// File: rtl/port_receiver_pkg.sv
// Shared definitions for the switch port receiver and transceiver: flit geometry,
// handshake state encoding and queue width helpers.
package port_receiver_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int ADDR_SIZE_DEF = 4;
    localparam int DEPTH_DEF     = 4;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    // The tail flag sits just above the destination address field.
    function automatic int tail_idx(input int addr_size);
        return addr_size;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through circular flit buffer; head entry is visible on dout
// without a read strobe, pops and pushes on a full/empty queue are ignored.
module flit_fifo
    import port_receiver_pkg::*;
#(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    parameter int PW    = ptr_width(DEPTH),
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          a_rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array write port
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            count_r <= CW'(0);
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/port_receiver.sv
// Switch input port: 4-phase wr_ready/r_ready handshake into a FWFT flit queue,
// with a count of complete packets (tail flits) resident in the queue.
module port_receiver
    import port_receiver_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BUS_SIZE  = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                       clk,
    input  logic                       a_rst_n,
    input  logic                       wr_ready_in,
    input  logic [BUS_SIZE-1:0]        data_i,
    input  logic                       mem_readed,
    output logic                       r_ready_out,
    output logic [BUS_SIZE-1:0]        data_o,
    output logic                       mem_empty,
    output logic                       mem_full,
    output logic [$clog2(DEPTH+1)-1:0] pkt_cnt
);

    localparam int CW   = cnt_width(DEPTH);
    localparam int TAIL = tail_idx(ADDR_SIZE);

    hs_state_e     state_r;
    hs_state_e     state_nxt_s;
    logic          push_s;
    logic          pop_ok_s;
    logic          tail_push_s;
    logic          tail_pop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW-1:0] pkt_cnt_r;

    flit_fifo #(
        .W     (BUS_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .push    (push_s),
        .pop     (mem_readed),
        .din     (data_i),
        .dout    (data_o),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (fifo_count_s)
    );

    // Handshake state register
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_r <= HS_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake next state; a full queue holds upstream waiting in IDLE
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        case (state_r)
            HS_IDLE: begin
                if (wr_ready_in && !fifo_full_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = HS_ACK;
                end else begin
                    state_nxt_s = HS_IDLE;
                end
            end
            HS_ACK: begin
                if (!wr_ready_in) begin
                    state_nxt_s = HS_IDLE;
                end else begin
                    state_nxt_s = HS_ACK;
                end
            end
            default: state_nxt_s = HS_IDLE;
        endcase
    end

    assign pop_ok_s    = mem_readed & ~fifo_empty_s;
    assign tail_push_s = push_s & data_i[TAIL];
    assign tail_pop_s  = pop_ok_s & data_o[TAIL];

    // Resident packet counter
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            pkt_cnt_r <= CW'(0);
        end else begin
            case ({tail_push_s, tail_pop_s})
                2'b10:   pkt_cnt_r <= pkt_cnt_r + CW'(1);
                2'b01:   pkt_cnt_r <= pkt_cnt_r - CW'(1);
                default: pkt_cnt_r <= pkt_cnt_r;
            endcase
        end
    end

    assign r_ready_out = (state_r == HS_ACK);
    assign mem_empty   = (fifo_count_s == CW'(0));
    assign mem_full    = (fifo_count_s == CW'(DEPTH));
    assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_port_receiver.sv
// Directed bench for port_receiver: a per-cycle vector table plus hand-written
// sequences for long strobes, pointer wrap and asynchronous reset.
module tb_port_receiver;

    localparam int BUS = 37;

    logic           clk;
    logic           a_rst_n;
    logic           wr_ready_in;
    logic [BUS-1:0] data_i;
    logic           mem_readed;
    logic           r_ready_out;
    logic [BUS-1:0] data_o;
    logic           mem_empty;
    logic           mem_full;
    logic [2:0]     pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    port_receiver dut (
        .clk         (clk),
        .a_rst_n     (a_rst_n),
        .wr_ready_in (wr_ready_in),
        .data_i      (data_i),
        .mem_readed  (mem_readed),
        .r_ready_out (r_ready_out),
        .data_o      (data_o),
        .mem_empty   (mem_empty),
        .mem_full    (mem_full),
        .pkt_cnt     (pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic           wr;
        logic [BUS-1:0] d;
        logic           rd;
        logic           rdy;
        logic           emp;
        logic           full;
        logic [2:0]     pkt;
        logic           dchk;
        logic [BUS-1:0] dexp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [BUS-1:0] mk(input logic [31:0] d, input logic t, input logic [3:0] a);
        return {d, t, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic wr, input logic [BUS-1:0] d, input logic rd,
                       input logic rdy, input logic emp, input logic full,
                       input logic [2:0] pkt, input logic dchk, input logic [BUS-1:0] dexp);
        vecs.push_back('{wr, d, rd, rdy, emp, full, pkt, dchk, dexp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [BUS-1:0] d, input logic rd);
        wr_ready_in = wr;
        data_i      = d;
        mem_readed  = rd;
    endtask

    logic [BUS-1:0] fa, f0, f1, f2, f3, f4, t0, n1, t2, fb, fl, fr, fw;
    logic [BUS-1:0] zero;

    initial begin
        zero = '0;
        fa = mk(32'h0000_00A0, 1'b1, 4'h3);
        f0 = mk(32'h0000_0100, 1'b0, 4'h0);
        f1 = mk(32'h0000_0101, 1'b0, 4'h1);
        f2 = mk(32'h0000_0102, 1'b0, 4'h2);
        f3 = mk(32'h0000_0103, 1'b0, 4'h3);
        f4 = mk(32'h0000_0104, 1'b0, 4'h4);
        t0 = mk(32'h0000_0200, 1'b1, 4'h1);
        n1 = mk(32'h0000_0201, 1'b0, 4'h2);
        t2 = mk(32'h0000_0202, 1'b1, 4'h5);
        fb = mk(32'h0000_0300, 1'b0, 4'h7);

        // wr, d, rd | rdy, emp, full, pkt, dchk, dexp
        add(1'b1, fa,   1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, fa);   // single flit accepted
        add(1'b0, fa,   1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, fa);   // release
        add(1'b0, zero, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, zero); // pop tail
        add(1'b1, f0,   1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, f0);   // fill
        add(1'b0, f0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f0);
        add(1'b1, f1,   1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, f0);
        add(1'b0, f1,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f0);
        add(1'b1, f2,   1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, f0);
        add(1'b0, f2,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f0);
        add(1'b1, f3,   1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, f0);   // now full
        add(1'b0, f3,   1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, f0);
        add(1'b1, f4,   1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, f0);   // backpressure
        add(1'b1, f4,   1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, f0);
        add(1'b1, f4,   1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f1);   // pop on full: no same-edge push
        add(1'b1, f4,   1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, f1);   // pending flit accepted
        add(1'b0, f4,   1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, f1);
        add(1'b0, zero, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f2);   // drain in order
        add(1'b0, zero, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f3);
        add(1'b0, zero, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, f4);
        add(1'b0, zero, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, zero);
        add(1'b1, t0,   1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, t0);   // two flits queued
        add(1'b0, t0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, t0);
        add(1'b1, n1,   1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, t0);
        add(1'b0, n1,   1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, t0);
        add(1'b1, t2,   1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, n1);   // push tail + pop tail
        add(1'b0, t2,   1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, t2);
        add(1'b0, zero, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, zero); // count was 2
        add(1'b0, zero, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, zero); // pop on empty ignored
        add(1'b1, fb,   1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, fb);
        add(1'b0, fb,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, fb);
        add(1'b0, zero, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, zero);

        a_rst_n = 1'b0;
        drive(1'b0, zero, 1'b0);
        #12;
        chk("reset r_ready_out", 64'(r_ready_out), 64'd0);
        chk("reset mem_empty",   64'(mem_empty),   64'd1);
        chk("reset mem_full",    64'(mem_full),    64'd0);
        chk("reset pkt_cnt",     64'(pkt_cnt),     64'd0);
        a_rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].d, vecs[i].rd);
            step();
            chk($sformatf("v%0d r_ready_out", i), 64'(r_ready_out), 64'(vecs[i].rdy));
            chk($sformatf("v%0d mem_empty", i),   64'(mem_empty),   64'(vecs[i].emp));
            chk($sformatf("v%0d mem_full", i),    64'(mem_full),    64'(vecs[i].full));
            chk($sformatf("v%0d pkt_cnt", i),     64'(pkt_cnt),     64'(vecs[i].pkt));
            if (vecs[i].dchk) begin
                chk($sformatf("v%0d data_o", i), 64'(data_o), 64'(vecs[i].dexp));
            end
        end

        // Long strobe: one push only, acknowledge held until release
        fl = mk(32'hCAFE_0001, 1'b1, 4'h9);
        drive(1'b1, fl, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("long c%0d r_ready_out", c), 64'(r_ready_out), 64'd1);
        end
        chk("long data_o", 64'(data_o), 64'(fl));
        chk("long pkt_cnt", 64'(pkt_cnt), 64'd1);
        drive(1'b0, zero, 1'b0);
        step();
        chk("long release", 64'(r_ready_out), 64'd0);
        drive(1'b0, zero, 1'b1);
        step();
        chk("long single push", 64'(mem_empty), 64'd1);
        chk("long pkt drained", 64'(pkt_cnt), 64'd0);

        // Pointer wrap: 3 packets of 3 flits, each popped after it lands
        for (int p = 0; p < 3; p++) begin
            for (int f = 0; f < 3; f++) begin
                fw = mk(32'h5000_0000 + 32'(p * 16 + f), (f == 2) ? 1'b1 : 1'b0, 4'(p + f));
                drive(1'b1, fw, 1'b0);
                step();
                chk($sformatf("wrap p%0d f%0d data_o", p, f), 64'(data_o), 64'(fw));
                chk($sformatf("wrap p%0d f%0d pkt_cnt", p, f), 64'(pkt_cnt), (f == 2) ? 64'd1 : 64'd0);
                drive(1'b0, zero, 1'b1);
                step();
                chk($sformatf("wrap p%0d f%0d empty", p, f), 64'(mem_empty), 64'd1);
            end
        end
        chk("wrap pkt_cnt end", 64'(pkt_cnt), 64'd0);

        // Async reset while in ACK with 3 flits queued
        drive(1'b1, mk(32'h7000_0000, 1'b1, 4'h1), 1'b0);
        step();
        drive(1'b0, zero, 1'b0);
        step();
        drive(1'b1, mk(32'h7000_0001, 1'b0, 4'h2), 1'b0);
        step();
        drive(1'b0, zero, 1'b0);
        step();
        drive(1'b1, mk(32'h7000_0002, 1'b1, 4'h3), 1'b0);
        step();
        chk("pre-reset pkt_cnt", 64'(pkt_cnt), 64'd2);
        chk("pre-reset r_ready_out", 64'(r_ready_out), 64'd1);
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("async r_ready_out", 64'(r_ready_out), 64'd0);
        chk("async mem_empty",   64'(mem_empty),   64'd1);
        chk("async pkt_cnt",     64'(pkt_cnt),     64'd0);
        drive(1'b0, zero, 1'b0);
        @(negedge clk);
        a_rst_n = 1'b1;
        fr = mk(32'h8000_0001, 1'b1, 4'h6);
        drive(1'b1, fr, 1'b0);
        step();
        chk("post-reset r_ready_out", 64'(r_ready_out), 64'd1);
        chk("post-reset data_o", 64'(data_o), 64'(fr));
        chk("post-reset pkt_cnt", 64'(pkt_cnt), 64'd1);
        drive(1'b0, zero, 1'b1);
        step();
        chk("post-reset drain", 64'(mem_empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
